// File: rtl/joystick_decoder_pkg.sv
// Shared constants, event-FSM state type and width helpers for the joystick/keypad decoder.
package joystick_pkg;

  localparam int LED_MODE_LATCH     = 0;
  localparam int LED_MODE_MOMENTARY = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } evt_state_e;

  function automatic int code_w(input int n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/joystick_decoder_if.sv
// Key pins in, decoded key/event/LED signals out; the decoder sits on the slave side.
interface joystick_decoder_if #(
  parameter int N_KEYS = 5,
  parameter int LED_W  = 4
);
  localparam int CODE_W = joystick_pkg::code_w(N_KEYS);

  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_state;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_evt;
  logic [LED_W-1:0]  led;

  modport master (output key_n, input key_state, key_valid, key_code, key_evt, led);
  modport slave  (input key_n, output key_state, key_valid, key_code, key_evt, led);
endinterface

// File: rtl/joystick_decoder_debounce.sv
// One key: two-flop synchroniser followed by a stability counter; output is active high.
module key_debounce
  import joystick_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic key_state_o
);
  localparam int              CW       = cnt_w(DEB_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_raw;

  assign pressed_raw = ~sync2_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (pressed_raw != state_q) begin
      if (cnt_q == CNT_LAST) state_d = ~state_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_state_o = state_q;
endmodule

// File: rtl/joystick_decoder.sv
// Debounced key bank -> fixed-priority key code -> press/auto-repeat events and an active-low LED bank.
module joystick_decoder
  import joystick_pkg::*;
#(
  parameter int N_KEYS       = 5,
  parameter int LED_W        = 4,
  parameter int DEB_CYCLES   = 16,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 1,
  parameter int LED_MODE     = LED_MODE_LATCH
) (
  input logic               clk,
  input logic               reset,
  joystick_decoder_if.slave bus
);
  localparam int                CODE_W   = code_w(N_KEYS);
  localparam int                RPT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int                CNT_W    = cnt_w(RPT_MAX);
  localparam logic [CNT_W-1:0]  DELAY_LD = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0]  RATE_LD  = CNT_W'(REPEAT_RATE);

  logic [N_KEYS-1:0] key_state;
  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d, evt_code_q, evt_code_d;
  logic              key_evt_q, key_evt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  evt_state_e        state_q, state_d;
  logic [LED_W-1:0]  led_q, led_d;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk         (clk),
      .reset       (reset),
      .key_n_i     (bus.key_n[g]),
      .key_state_o (key_state[g])
    );
  end

  // Codes beyond the LED bank light every LED.
  function automatic logic [LED_W-1:0] pattern(input logic [CODE_W-1:0] code);
    logic [LED_W-1:0] p;
    for (int i = 0; i < LED_W; i++) p[i] = (int'(code) == i) ? 1'b0 : 1'b1;
    if (int'(code) >= LED_W) p = '0;
    return p;
  endfunction

  // Scan downwards so the lowest set index wins.
  always_comb begin
    key_code_d  = '0;
    key_valid_d = |key_state;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (key_state[i]) key_code_d = CODE_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_evt_d  = 1'b0;
    evt_code_d = evt_code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_valid_q) begin
          key_evt_d = 1'b1;
          cnt_d     = DELAY_LD;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD, ST_RPT: begin
        // Release outranks a simultaneous code change.
        if (!key_valid_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (key_code_q != evt_code_q) begin
          key_evt_d = 1'b1;
          cnt_d     = DELAY_LD;
          state_d   = ST_HOLD;
        end else if (REPEAT_DELAY != 0) begin
          if (cnt_q == CNT_W'(1)) begin
            key_evt_d = 1'b1;
            cnt_d     = RATE_LD;
            state_d   = ST_RPT;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (key_evt_d) evt_code_d = key_code_q;
  end

  always_comb begin
    if (LED_MODE == LED_MODE_MOMENTARY) led_d = key_valid_q ? pattern(key_code_q) : '1;
    else                                led_d = key_evt_d ? pattern(key_code_q) : led_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      evt_code_q  <= '0;
      key_evt_q   <= 1'b0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      led_q       <= '1;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      evt_code_q  <= evt_code_d;
      key_evt_q   <= key_evt_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      led_q       <= led_d;
    end
  end

  assign bus.key_state = key_state;
  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_evt   = key_evt_q;
  assign bus.led       = led_q;
endmodule

// File: tb/tb_joystick_decoder.sv
// Directed bench: one latched-LED and one momentary-LED decoder driven from the same key pins.
module tb_joystick_decoder;
  import joystick_pkg::*;

  localparam int N_KEYS = 5;
  localparam int LED_W  = 4;
  localparam int DEB    = 4;
  localparam int RD     = 10;
  localparam int RR     = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_KEYS-1:0] key_n;
  int                n_checks = 0;
  int                n_fail   = 0;

  joystick_decoder_if #(.N_KEYS(N_KEYS), .LED_W(LED_W)) bus_l ();
  joystick_decoder_if #(.N_KEYS(N_KEYS), .LED_W(LED_W)) bus_m ();

  assign bus_l.key_n = key_n;
  assign bus_m.key_n = key_n;

  joystick_decoder #(
    .N_KEYS(N_KEYS), .LED_W(LED_W), .DEB_CYCLES(DEB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .LED_MODE(LED_MODE_LATCH)
  ) u_dut_l (.clk(clk), .reset(reset), .bus(bus_l.slave));

  joystick_decoder #(
    .N_KEYS(N_KEYS), .LED_W(LED_W), .DEB_CYCLES(DEB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .LED_MODE(LED_MODE_MOMENTARY)
  ) u_dut_m (.clk(clk), .reset(reset), .bus(bus_m.slave));

  always #5 clk = ~clk;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n_evt = 0;
    reset = 1'b0;
    key_n = '1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    n_checks++;
    if (bus_l.led !== 4'b1111) begin n_fail++; $display("FAIL reset_led_latch: got %b expected 1111", bus_l.led); end
    n_checks++;
    if (bus_m.led !== 4'b1111) begin n_fail++; $display("FAIL reset_led_mom: got %b expected 1111", bus_m.led); end
    n_checks++;
    if (bus_l.key_state !== 5'b00000) begin n_fail++; $display("FAIL reset_key_state: got %b expected 00000", bus_l.key_state); end
    n_checks++;
    if (bus_l.key_valid !== 1'b0 || bus_l.key_code !== 3'd0) begin
      n_fail++; $display("FAIL reset_valid_code: got valid=%b code=%0d expected 0/0", bus_l.key_valid, bus_l.key_code);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus_l.key_evt !== 1'b0 || bus_m.key_evt !== 1'b0) n_evt++;
    end
    n_checks++;
    if (n_evt != 0) begin n_fail++; $display("FAIL idle_no_evt: got %0d events expected 0", n_evt); end
  endtask

  task automatic test_single_key();
    int n_evt = 0;
    key_n = 5'b11101;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus_l.key_evt === 1'b1) n_evt++;
      if (i == 5) begin
        n_checks++;
        if (bus_l.key_state !== 5'b00000) begin n_fail++; $display("FAIL deb_early: got %b expected 00000", bus_l.key_state); end
      end
      if (i == 6) begin
        n_checks++;
        if (bus_l.key_state !== 5'b00010) begin n_fail++; $display("FAIL deb_rise: got %b expected 00010", bus_l.key_state); end
      end
      if (i == 8) begin
        n_checks++;
        if (bus_l.key_evt !== 1'b1 || bus_l.key_code !== 3'd1) begin
          n_fail++; $display("FAIL single_evt: got evt=%b code=%0d expected 1/1", bus_l.key_evt, bus_l.key_code);
        end
      end
      if (i == 9) begin
        n_checks++;
        if (bus_l.led !== 4'b1101) begin n_fail++; $display("FAIL single_led: got %b expected 1101", bus_l.led); end
      end
      if (i == 10) key_n = '1;
    end
    n_checks++;
    if (bus_l.led !== 4'b1101 || bus_l.key_valid !== 1'b0) begin
      n_fail++; $display("FAIL latch_hold: got led=%b valid=%b expected 1101/0", bus_l.led, bus_l.key_valid);
    end
    n_checks++;
    if (n_evt != 1) begin n_fail++; $display("FAIL single_evt_count: got %0d expected 1", n_evt); end
  endtask

  task automatic test_glitch();
    int n_evt  = 0;
    int n_seen = 0;
    key_n = 5'b11011;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i == 3) key_n = '1;
      if (bus_l.key_state !== 5'b00000) n_seen++;
      if (bus_l.key_evt !== 1'b0) n_evt++;
    end
    n_checks++;
    if (n_seen != 0) begin n_fail++; $display("FAIL glitch_state: got %0d cycles with a key expected 0", n_seen); end
    n_checks++;
    if (n_evt != 0) begin n_fail++; $display("FAIL glitch_evt: got %0d events expected 0", n_evt); end
    n_checks++;
    if (bus_l.led !== 4'b1101) begin n_fail++; $display("FAIL glitch_led: got %b expected 1101", bus_l.led); end
  endtask

  // Key 0 held 40 clocks: first event at 8, repeats at 18, 23, ... 43; FSM idles at 48.
  task automatic test_auto_repeat();
    logic exp_evt;
    key_n = 5'b11110;
    for (int i = 1; i <= 55; i++) begin
      step();
      if (i == 40) key_n = '1;
      exp_evt = (i == 8) || (i >= 18 && i <= 43 && ((i - 18) % 5) == 0);
      n_checks++;
      if (bus_m.key_evt !== exp_evt) begin
        n_fail++; $display("FAIL repeat_evt@%0d: got %b expected %b", i, bus_m.key_evt, exp_evt);
      end
      if (i == 7 || i == 48) begin
        n_checks++;
        if (bus_m.led !== 4'b1111) begin n_fail++; $display("FAIL mom_led_off@%0d: got %b expected 1111", i, bus_m.led); end
      end
      if (i == 8 || i == 47) begin
        n_checks++;
        if (bus_m.led !== 4'b1110) begin n_fail++; $display("FAIL mom_led_on@%0d: got %b expected 1110", i, bus_m.led); end
      end
    end
  endtask

  // Key 4 held, key 3 added then released, then key 4 released; events at 8, 16, 26 only.
  task automatic test_priority();
    logic exp_evt;
    key_n = 5'b01111;
    for (int i = 1; i <= 45; i++) begin
      step();
      if (i == 8)  key_n = 5'b00111;
      if (i == 18) key_n = 5'b01111;
      if (i == 28) key_n = '1;
      exp_evt = (i == 8) || (i == 16) || (i == 26);
      n_checks++;
      if (bus_l.key_evt !== exp_evt) begin
        n_fail++; $display("FAIL prio_evt@%0d: got %b expected %b", i, bus_l.key_evt, exp_evt);
      end
      if (i == 7 || i == 25) begin
        n_checks++;
        if (bus_l.key_code !== 3'd4) begin n_fail++; $display("FAIL prio_code4@%0d: got %0d expected 4", i, bus_l.key_code); end
      end
      if (i == 15) begin
        n_checks++;
        if (bus_l.key_code !== 3'd3) begin n_fail++; $display("FAIL prio_code3: got %0d expected 3", bus_l.key_code); end
      end
      if (i == 9 || i == 27 || i == 45) begin
        n_checks++;
        if (bus_l.led !== 4'b0000) begin n_fail++; $display("FAIL prio_led_all@%0d: got %b expected 0000", i, bus_l.led); end
      end
      if (i == 17) begin
        n_checks++;
        if (bus_l.led !== 4'b0111) begin n_fail++; $display("FAIL prio_led3: got %b expected 0111", bus_l.led); end
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic exp_evt;
    key_n = 5'b11110;
    repeat (25) step();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus_l.key_state !== 5'b00000 || bus_l.key_valid !== 1'b0 || bus_l.key_code !== 3'd0) begin
      n_fail++; $display("FAIL midreset_key: got state=%b valid=%b code=%0d expected 00000/0/0",
                         bus_l.key_state, bus_l.key_valid, bus_l.key_code);
    end
    n_checks++;
    if (bus_l.key_evt !== 1'b0 || bus_l.led !== 4'b1111 || bus_m.led !== 4'b1111) begin
      n_fail++; $display("FAIL midreset_out: got evt=%b led_l=%b led_m=%b expected 0/1111/1111",
                         bus_l.key_evt, bus_l.led, bus_m.led);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp_evt = (i == DEB + 4) || (i == DEB + 4 + RD);
      n_checks++;
      if (bus_l.key_evt !== exp_evt) begin
        n_fail++; $display("FAIL post_reset_evt@%0d: got %b expected %b", i, bus_l.key_evt, exp_evt);
      end
    end
    n_checks++;
    if (bus_l.led !== 4'b1110) begin n_fail++; $display("FAIL post_reset_led: got %b expected 1110", bus_l.led); end
    key_n = '1;
    repeat (20) step();
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_glitch();
    test_auto_repeat();
    test_priority();
    test_reset_mid_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
